// File: rtl/softex_cast_out_ctrl.sv
// Job-level sequencer for the output cast stage: latches one cast configuration per job
// and opens the stream handshake into the cast stage for exactly the programmed beat count.
module softex_cast_out_ctrl #(
    parameter int unsigned INT_WIDTH  = 8,
    parameter int unsigned BEAT_CNT_W = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          job_valid_i,
    output logic                          job_ready_o,
    input  logic                          job_enable_i,
    input  logic                          job_is_signed_i,
    input  logic [$clog2(INT_WIDTH):0]    job_int_bits_i,
    input  logic [BEAT_CNT_W-1:0]         job_num_beats_i,
    output logic [$clog2(INT_WIDTH)+2:0]  ctrl_o,        // packed cast_ctrl_t {enable, is_signed, int_bits}
    input  logic                          up_valid_i,
    output logic                          up_ready_o,
    output logic                          cast_valid_o,
    input  logic                          cast_ready_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [BEAT_CNT_W-1:0]         beat_cnt_o,
    output logic                          cfg_err_o
);

    localparam int unsigned INT_BITS_W = $clog2(INT_WIDTH) + 1;

    typedef struct packed {
        logic                  enable;
        logic                  is_signed;
        logic [INT_BITS_W-1:0] int_bits;
    } cast_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [INT_BITS_W-1:0] INT_WIDTH_V = INT_BITS_W'(INT_WIDTH);
    localparam logic [BEAT_CNT_W-1:0] ONE_BEAT    = BEAT_CNT_W'(1);

    state_t                state_reg;
    cast_ctrl_t            ctrl_reg;
    logic [BEAT_CNT_W-1:0] beat_cnt_reg;
    logic [BEAT_CNT_W-1:0] num_beats_reg;
    logic                  cfg_err_reg;

    logic run;
    logic beat;
    logic last_beat;
    logic int_bits_bad;

    // The stream is only open in RUN, so no beat can slip through before
    // configuration or after the count is exhausted.
    assign run          = (state_reg == RUN);
    assign beat         = run & up_valid_i & cast_ready_i;
    assign last_beat    = ((beat_cnt_reg + ONE_BEAT) == num_beats_reg);
    assign int_bits_bad = (job_int_bits_i == '0) || (job_int_bits_i > INT_WIDTH_V);

    assign job_ready_o  = (state_reg == IDLE) & ~clear_i;
    assign cast_valid_o = run & up_valid_i;
    assign up_ready_o   = run & cast_ready_i;
    assign busy_o       = (state_reg != IDLE);
    assign done_o       = (state_reg == DONE);
    assign ctrl_o       = ctrl_reg;
    assign beat_cnt_o   = beat_cnt_reg;
    assign cfg_err_o    = cfg_err_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            ctrl_reg      <= '0;
            beat_cnt_reg  <= '0;
            num_beats_reg <= '0;
            cfg_err_reg   <= 1'b0;
        end else if (clear_i) begin
            // Abort: configuration and error flag survive, progress does not.
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (job_valid_i) begin
                        ctrl_reg.enable    <= job_enable_i;
                        ctrl_reg.is_signed <= job_is_signed_i;
                        ctrl_reg.int_bits  <= int_bits_bad ? INT_WIDTH_V : job_int_bits_i;
                        cfg_err_reg        <= int_bits_bad;
                        num_beats_reg      <= job_num_beats_i;
                        beat_cnt_reg       <= '0;
                        state_reg          <= (job_num_beats_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + ONE_BEAT;
                        if (last_beat) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/softex_cast_out_ctrl.md
Name: softex_cast_out_ctrl

Overview:
Job-level sequencer for the output cast stage of the accelerator datapath. It accepts one cast job at a time over a valid/ready config handshake. It latches the cast configuration into the cast stage's control struct, then gates the stream handshake into the cast stage for exactly the programmed number of beats. It sits between the streamer/normalization output and the FP-to-int cast stage, and reports busy/done to the accelerator controller.

Parameters:
INT_WIDTH, INT_W, maximum integer output width in bits; legal int_bits range is 1..INT_WIDTH.
BEAT_CNT_W, 16, width of the beat counter and of the job length field.
INT_BITS_W, $clog2(INT_WIDTH)+1, width of the int_bits config field (derived; do not override).

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
clear_i  in  1  synchronous soft clear/abort, active-high
job_valid_i  in  1  job config valid
job_ready_o  out  1  job config accepted when high together with job_valid_i
job_enable_i  in  1  cast enable; 0 = pass-through
job_is_signed_i  in  1  signed integer output
job_int_bits_i  in  INT_BITS_W  integer bits of output format
job_num_beats_i  in  BEAT_CNT_W  stream beats in job
ctrl_o  out  cast_ctrl_t  latched config to cast stage (fields enable, is_signed, int_bits)
up_valid_i  in  1  upstream stream valid
up_ready_o  out  1  upstream stream ready
cast_valid_o  out  1  valid into cast stage
cast_ready_i  in  1  ready from cast stage
busy_o  out  1  job in progress (RUN or DONE)
done_o  out  1  one-cycle pulse at job completion
beat_cnt_o  out  BEAT_CNT_W  beats transferred in current job
cfg_err_o  out  1  sticky: last accepted job had illegal int_bits

Behaviour:
- Reset (rst_ni=0 at posedge): state=IDLE; ctrl_o all zero; beat_cnt_o=0; done_o=0; cfg_err_o=0; busy_o=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - job_ready_o = ~clear_i.
  - On job_valid_i & job_ready_o, latch enable and is_signed into ctrl_o, and latch num_beats internally.
  - Clear beat_cnt_o and cfg_err_o.
  - If num_beats==0, go to DONE. Otherwise go to RUN.
- int_bits legality:
  - int_bits==0 or >INT_WIDTH: ctrl_o.int_bits=INT_WIDTH and cfg_err_o=1 (sticky until the next accept).
  - Otherwise ctrl_o.int_bits = job_int_bits_i.
- RUN:
  - cast_valid_o = up_valid_i; up_ready_o = cast_ready_i. Both are combinational passthrough.
  - Each beat is a cycle with up_valid_i & cast_ready_i; it increments beat_cnt_o.
  - When a beat occurs with beat_cnt_o == num_beats-1, beat_cnt_o becomes num_beats and state goes to DONE.
- Outside RUN: cast_valid_o=0 and up_ready_o=0. No beat can leak before configuration or after the count ends.
- DONE: lasts exactly one cycle. done_o=1, job_ready_o=0, then go to IDLE.
- busy_o = (state != IDLE).
- ctrl_o changes only on job accept. It is held through RUN, DONE and IDLE, so the config never changes mid-stream.
- clear_i has priority over everything except reset. On clear_i:
  - State goes to IDLE at the next edge and beat_cnt_o becomes 0.
  - done_o is not pulsed, even if the last beat coincides with clear.
  - ctrl_o and cfg_err_o are retained.
  - A job presented in the same cycle is not accepted.
- Gating outputs during a clear cycle in RUN still follow RUN rules. The beat transfers but is discarded by the abort.
- Reset asserted mid-job returns to the reset values at the next edge regardless of handshake state.
- Latency:
  - Job accept to first possible beat: 1 cycle.
  - Last beat to done_o: done_o is high in the cycle after the last beat.
  - Next job can be accepted 2 cycles after the last beat.
- beat_cnt_o saturates nowhere. num_beats max 2^BEAT_CNT_W-1 cannot overflow the counter.

Test Plan:
- Reset, then job {enable=1, is_signed=0, int_bits=8, num_beats=4}, with up_valid_i and cast_ready_i held high.
  -> ctrl_o = {1,0,8} the cycle after accept; exactly 4 cast_valid_o&cast_ready_i beats; done_o high one cycle; busy_o low after; beat_cnt_o=4.
- Same job with cast_ready_i toggling 1,0,0,1,... and up_valid_i random.
  -> beats counted only on up_valid_i&cast_ready_i; up_ready_o=0 during stalls; done_o after the 4th beat; no 5th beat passes even with up_valid_i held high.
- num_beats=0.
  -> accept; next cycle DONE with done_o=1; zero beats; cast_valid_o stays 0.
- int_bits=0, then next job int_bits=INT_WIDTH+3.
  -> ctrl_o.int_bits=INT_WIDTH and cfg_err_o=1 in both cases; cfg_err_o=0 after a subsequent job with int_bits=4.
- clear_i asserted in RUN at beat 2 of 8, including one run where clear coincides with the final beat.
  -> IDLE next cycle; beat_cnt_o=0; no done_o; ctrl_o unchanged; new job accepted on the following cycle.
- job_valid_i held high during RUN, and rst_ni pulsed low mid-job.
  -> job_ready_o=0 while busy; after reset all outputs zero and state IDLE.
